// File: rtl/sevenseg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_scan_ctrl_if
// Brief  : Load handshake bundle (valid/ready + BCD digits + zero-suppress flag)
// Rev    : 1.0  initial release
// ============================================================================
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_bcd;
    logic                    load_lzs;

    modport master (
        output load_valid,
        output load_bcd,
        output load_lzs,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_bcd,
        input  load_lzs,
        output load_ready
    );
endinterface
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_scan_ctrl
// Brief  : Multiplexed seven-segment scan controller with frame-aligned loads.
//          Optional brightness PWM when SEVENSEG_DIMMING_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    sevenseg_scan_ctrl_if.slave        load_if,
`ifdef SEVENSEG_DIMMING_EN
    input  wire logic [3:0]            bright,
`endif
    output logic      [6:0]            seg,
    output logic      [NUM_DIGITS-1:0] dig_en_n,
    output logic                       frame_done
);

    localparam int C_CNT_W        = $clog2(REFRESH_DIV);
    localparam int C_IDX_W        = $clog2(NUM_DIGITS);
    localparam int C_BCD_W        = 4 * NUM_DIGITS;
    localparam int C_DRIVE_CYCLES = REFRESH_DIV - BLANK_CYCLES;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [C_CNT_W-1:0]    cnt_q, cnt_d;
    logic [C_IDX_W-1:0]    idx_q, idx_d;
    logic [C_BCD_W-1:0]    active_q, active_d;
    logic                  lzs_q, lzs_d;
    logic [C_BCD_W-1:0]    pend_q, pend_d;
    logic                  pend_lzs_q, pend_lzs_d;
    logic                  pend_full_q, pend_full_d;
    logic                  ready_q, ready_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_en_n_q, dig_en_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [NUM_DIGITS-1:0] w_dark;
    logic                  w_seen_nz;
    logic [3:0]            w_cur;
    logic                  w_cur_dark;
    logic                  w_duty_on;
    logic                  w_lit;

    assign w_slot_end  = (cnt_q == C_CNT_W'(REFRESH_DIV - 1));
    assign w_frame_end = w_slot_end && (idx_q == C_IDX_W'(NUM_DIGITS - 1));

    // Position, handshake and frame-boundary commit
    always_comb begin
        cnt_d       = w_slot_end ? '0 : cnt_q + C_CNT_W'(1);
        idx_d       = idx_q;
        active_d    = active_q;
        lzs_d       = lzs_q;
        pend_d      = pend_q;
        pend_lzs_d  = pend_lzs_q;
        pend_full_d = pend_full_q;
        if (w_slot_end) begin
            idx_d = (idx_q == C_IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + C_IDX_W'(1);
        end
        if (w_frame_end && pend_full_q) begin
            active_d    = pend_q;
            lzs_d       = pend_lzs_q;
            pend_full_d = 1'b0;
        end
        if (load_if.load_valid && ready_q) begin
            pend_d      = load_if.load_bcd;
            pend_lzs_d  = load_if.load_lzs;
            pend_full_d = 1'b1;
        end
        ready_d = !pend_full_d;
    end

    // Walk from the most significant digit; zeros stay dark until a nonzero appears
    always_comb begin
        w_seen_nz = 1'b0;
        w_dark    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (active_d[4*k +: 4] != 4'd0) begin
                w_seen_nz = 1'b1;
            end
            w_dark[k] = (active_d[4*k +: 4] > 4'd9) || (lzs_d && !w_seen_nz && (k != 0));
        end
    end

`ifdef SEVENSEG_DIMMING_EN
    logic [3:0]  bright_q, bright_d;
    logic [31:0] w_on_cycles;

    assign bright_d    = w_frame_end ? bright : bright_q;
    assign w_on_cycles = ((32'(bright_d) + 32'd1) * 32'(C_DRIVE_CYCLES)) >> 4;
    assign w_duty_on   = (32'(cnt_d) - 32'(BLANK_CYCLES)) < w_on_cycles;
`else
    assign w_duty_on   = 1'b1;
`endif

    // Outputs are computed for the upcoming position so they land in step with cnt
    always_comb begin
        w_cur        = 4'hF;
        w_cur_dark   = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == C_IDX_W'(k)) begin
                w_cur      = active_d[4*k +: 4];
                w_cur_dark = w_dark[k];
            end
        end
        w_lit        = (cnt_d >= C_CNT_W'(BLANK_CYCLES)) && !w_cur_dark;
        seg_d        = w_lit ? decode(w_cur) : 7'h7F;
        dig_en_n_d   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == C_IDX_W'(k)) begin
                dig_en_n_d[k] = !(w_lit && w_duty_on);
            end
        end
        frame_done_d = (cnt_d == C_CNT_W'(REFRESH_DIV - 1)) &&
                       (idx_d == C_IDX_W'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '1;
            lzs_q        <= 1'b0;
            pend_q       <= '0;
            pend_lzs_q   <= 1'b0;
            pend_full_q  <= 1'b0;
            ready_q      <= 1'b0;
            seg_q        <= 7'h7F;
            dig_en_n_q   <= '1;
            frame_done_q <= 1'b0;
`ifdef SEVENSEG_DIMMING_EN
            bright_q     <= 4'hF;
`endif
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            lzs_q        <= lzs_d;
            pend_q       <= pend_d;
            pend_lzs_q   <= pend_lzs_d;
            pend_full_q  <= pend_full_d;
            ready_q      <= ready_d;
            seg_q        <= seg_d;
            dig_en_n_q   <= dig_en_n_d;
            frame_done_q <= frame_done_d;
`ifdef SEVENSEG_DIMMING_EN
            bright_q     <= bright_d;
`endif
        end
    end

    assign seg                = seg_q;
    assign dig_en_n           = dig_en_n_q;
    assign frame_done         = frame_done_q;
    assign load_if.load_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sevenseg_scan_ctrl
// Brief  : Randomized bench for sevenseg_scan_ctrl against a frame-position model
// Rev    : 1.0  initial release
// ============================================================================
module tb_sevenseg_scan_ctrl;
    localparam int N     = 4;
    localparam int R     = 16;
    localparam int B     = 4;
    localparam int FRAME = N * R;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sevenseg_scan_ctrl_if #(.NUM_DIGITS(N)) lif ();
    logic [6:0]   seg;
    logic [N-1:0] dig_en_n;
    logic         frame_done;
`ifdef SEVENSEG_DIMMING_EN
    logic [3:0]   bright;
`endif

    sevenseg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_if    (lif),
`ifdef SEVENSEG_DIMMING_EN
        .bright     (bright),
`endif
        .seg        (seg),
        .dig_en_n   (dig_en_n),
        .frame_done (frame_done)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: one position counter across the whole frame plus digit arrays
    int m_t;
    int m_active [N];
    int m_pend   [N];
    bit m_lzs, m_pend_lzs, m_pend_full, m_after_rst;
    int m_bright;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit digit_lit(input int k);
        int hi = -1;
        for (int j = 0; j < N; j++) if (m_active[j] != 0) hi = j;
        if (m_active[k] > 9) return 1'b0;
        if (m_lzs && k != 0 && k > hi) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit duty_ok(input int c);
`ifdef SEVENSEG_DIMMING_EN
        return (c - B) < (((m_bright + 1) * (R - B)) >> 4);
`else
        return (c >= B);
`endif
    endfunction

    always @(posedge clk) begin : model
        bit rdy;
        if (rst) begin
            m_t         = 0;
            for (int k = 0; k < N; k++) m_active[k] = 15;
            m_lzs       = 1'b0;
            m_pend_full = 1'b0;
            m_after_rst = 1'b1;
            m_bright    = 15;
        end else begin
            rdy = !m_pend_full && !m_after_rst;
            if (m_t == FRAME - 1) begin
                if (m_pend_full) begin
                    for (int k = 0; k < N; k++) m_active[k] = m_pend[k];
                    m_lzs       = m_pend_lzs;
                    m_pend_full = 1'b0;
                end
`ifdef SEVENSEG_DIMMING_EN
                m_bright = int'(bright);
`endif
            end
            if (lif.load_valid && rdy) begin
                for (int k = 0; k < N; k++) m_pend[k] = int'(lif.load_bcd[4*k +: 4]);
                m_pend_lzs  = lif.load_lzs;
                m_pend_full = 1'b1;
            end
            m_t         = (m_t + 1) % FRAME;
            m_after_rst = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        int slot, c;
        bit on;
        logic [6:0]   es;
        logic [N-1:0] een, one;
        if (chk_en) begin
            slot = m_t / R;
            c    = m_t % R;
            on   = (c >= B) && digit_lit(slot);
            es   = on ? seg_tab[m_active[slot]] : 7'h7F;
            one  = 1;
            een  = '1;
            if (on && duty_ok(c)) een = ~(one << slot);
            check("seg", 32'(seg), 32'(es));
            check("dig_en_n", 32'(dig_en_n), 32'(een));
            check("frame_done", 32'(frame_done), 32'(m_t == FRAME - 1));
            check("load_ready", 32'(lif.load_ready), 32'(!m_pend_full && !m_after_rst));
        end
    end

    task automatic wait_pos(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_t != p && n < 2 * FRAME + 4);
        if (m_t != p) begin
            checks++;
            failures++;
            $display("FAIL wait_pos: position %0d never reached, at %0d", p, m_t);
        end
    endtask

    task automatic lit(input string name, input logic [6:0] es, input logic [N-1:0] een);
        check({name, "_seg"}, 32'(seg), 32'(es));
        check({name, "_en"}, 32'(dig_en_n), 32'(een));
    endtask

    task automatic do_load(input logic [15:0] v, input bit z);
        int n = 0;
        while (!lif.load_ready && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (!lif.load_ready) begin
            checks++;
            failures++;
            $display("FAIL do_load: ready stayed 0, got %0b expected 1", lif.load_ready);
        end
        lif.load_valid = 1'b1;
        lif.load_bcd   = v;
        lif.load_lzs   = z;
        @(negedge clk);
        lif.load_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int k = 0; k < N; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            v[4*k +: 4] = (r < 4) ? 4'd0 :
                          (r == 9) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(1, 9));
        end
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        lif.load_valid = 1'b0;
        lif.load_bcd   = '0;
        lif.load_lzs   = 1'b0;
`ifdef SEVENSEG_DIMMING_EN
        bright         = 4'd3;
`endif
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_ready", 32'(lif.load_ready), 32'd0);
        rst = 1'b0;

        // Idle frame after reset
        wait_pos(10);
        lit("idle", 7'h7F, 4'hF);
        wait_pos(FRAME - 1);
        check("idle_fd63", 32'(frame_done), 32'd1);
        check("idle_ready", 32'(lif.load_ready), 32'd1);

        // 1234, no suppression
        do_load(16'h1234, 1'b0);
        wait_pos(FRAME - 1);
        wait_pos(4);
        lit("d1234_s0", 7'b1001100, 4'b1110);
        wait_pos(R + 3);
        lit("d1234_blank", 7'h7F, 4'hF);
        wait_pos(3 * R + 5);
        lit("d1234_s3", 7'b1001111, 4'b0111);

        // 0050 with leading-zero suppression
        do_load(16'h0050, 1'b1);
        wait_pos(FRAME - 1);
        wait_pos(5);
        lit("lz50_s0", 7'b0000001, 4'b1110);
        wait_pos(R + 5);
        lit("lz50_s1", 7'b0100100, 4'b1101);
        wait_pos(2 * R + 5);
        lit("lz50_s2", 7'h7F, 4'hF);
        wait_pos(3 * R + 5);
        lit("lz50_s3", 7'h7F, 4'hF);

        // All zeros with suppression: only digit 0 lit
        do_load(16'h0000, 1'b1);
        wait_pos(FRAME - 1);
        wait_pos(5);
        lit("lz0_s0", 7'b0000001, 4'b1110);
        wait_pos(R + 5);
        lit("lz0_s1", 7'h7F, 4'hF);

        // Invalid code in digit 1
        do_load(16'h12A4, 1'b0);
        wait_pos(FRAME - 1);
        wait_pos(5);
        lit("inv_s0", 7'b1001100, 4'b1110);
        wait_pos(R + 5);
        lit("inv_s1", 7'h7F, 4'hF);
        wait_pos(2 * R + 5);
        lit("inv_s2", 7'b0010010, 4'b1011);
        wait_pos(3 * R + 5);
        lit("inv_s3", 7'b1001111, 4'b0111);

        // Back-to-back loads
        wait_pos(5);
        do_load(16'h1111, 1'b0);
        lif.load_valid = 1'b1;
        lif.load_bcd   = 16'h2222;
        lif.load_lzs   = 1'b0;
        wait_pos(FRAME - 1);
        check("b2b_ready_fd", 32'(lif.load_ready), 32'd0);
        @(negedge clk);
        check("b2b_ready_after", 32'(lif.load_ready), 32'd1);
        @(negedge clk);
        lif.load_valid = 1'b0;
        wait_pos(6);
        lit("b2b_first", 7'b1001111, 4'b1110);
        wait_pos(FRAME - 1);
        wait_pos(6);
        lit("b2b_second", 7'b0010010, 4'b1110);

        // Mid-frame reset discards pending data
        do_load(16'h5678, 1'b0);
        wait_pos(FRAME - 1);
        wait_pos(3);
        do_load(16'h9999, 1'b0);
        wait_pos(2 * R + 5);
        lit("pre_rst_s2", 7'b0100000, 4'b1011);
        rst = 1'b1;
        @(negedge clk);
        lit("mid_rst", 7'h7F, 4'hF);
        check("mid_rst_ready", 32'(lif.load_ready), 32'd0);
        rst = 1'b0;
        wait_pos(FRAME - 1);
        wait_pos(6);
        lit("pend_lost", 7'h7F, 4'hF);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if (!(lif.load_valid && !lif.load_ready)) begin
                lif.load_valid = ($urandom_range(0, 2) == 0);
                lif.load_bcd   = rand_bcd();
                lif.load_lzs   = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 7) == 0) begin
                lif.load_valid = 1'b0;
            end
        end
        @(negedge clk);
        rst            = 1'b0;
        lif.load_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
